// File: rtl/sync_fifo_pkg.sv
// Shared defaults and the count type for the sync_fifo block.
// Optional error outputs are enabled in sync_fifo with SYNC_FIFO_ERR_EN.
package sync_fifo_pkg;

   localparam int SYNC_FIFO_DATA_WIDTH = 8;
   localparam int SYNC_FIFO_DEPTH      = 16;
   localparam int SYNC_FIFO_ADDR_WIDTH = 4;

   typedef logic [SYNC_FIFO_ADDR_WIDTH:0] sync_fifo_count_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Dual-port register array: synchronous write port, registered read port.
// Array contents are not reset; only the read register is.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = SYNC_FIFO_DATA_WIDTH,
   parameter int FIFO_DEPTH = SYNC_FIFO_DEPTH,
   parameter int ADDR_WIDTH = SYNC_FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_en,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   output logic [DATA_WIDTH-1:0] r_data
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (w_en) mem[w_addr] <= w_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_data <= '0;
      else if (r_en) r_data <= mem[r_addr];
   end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with empty/full flags and occupancy/free-space counts.
// Define SYNC_FIFO_ERR_EN to add registered overflow/underflow pulses.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = SYNC_FIFO_DATA_WIDTH,
   parameter int FIFO_DEPTH = SYNC_FIFO_DEPTH,
   parameter int ADDR_WIDTH = SYNC_FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic                  r_en,
   output logic [DATA_WIDTH-1:0] r_data,
   output logic                  is_empty,
   output logic                  is_full,
   output logic [ADDR_WIDTH:0]   room_avail,
   output logic [ADDR_WIDTH:0]   data_avail
`ifdef SYNC_FIFO_ERR_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count;
   logic                  wr_acc;
   logic                  rd_acc;

   assign is_empty   = (count == '0);
   assign is_full    = (count == DEPTH_C);
   assign data_avail = count;
   assign room_avail = DEPTH_C - count;

   // Flags gate acceptance, so a full FIFO can still read and an empty one still write.
   assign wr_acc = w_en && !is_full;
   assign rd_acc = r_en && !is_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
         if (wr_acc && !rd_acc)      count <= count + 1'b1;
         else if (rd_acc && !wr_acc) count <= count - 1'b1;
      end
   end

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk    (clk),
      .rst    (rst),
      .w_en   (wr_acc),
      .w_addr (wr_ptr),
      .w_data (w_data),
      .r_en   (rd_acc),
      .r_addr (rd_ptr),
      .r_data (r_data)
   );

`ifdef SYNC_FIFO_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= w_en && is_full;
         underflow <= r_en && is_empty;
      end
   end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo against a queue-based reference model.
// Compile with SYNC_FIFO_ERR_EN defined to also check overflow/underflow.
module tb_sync_fifo;
   import sync_fifo_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          w_en;
   logic [DW-1:0] w_data;
   logic          r_en;
   logic [DW-1:0] r_data;
   logic          is_empty;
   logic          is_full;
   logic [AW:0]   room_avail;
   logic [AW:0]   data_avail;
`ifdef SYNC_FIFO_ERR_EN
   logic          overflow;
   logic          underflow;
`endif

   sync_fifo #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .w_en       (w_en),
      .w_data     (w_data),
      .r_en       (r_en),
      .r_data     (r_data),
      .is_empty   (is_empty),
      .is_full    (is_full),
      .room_avail (room_avail),
      .data_avail (data_avail)
`ifdef SYNC_FIFO_ERR_EN
      ,
      .overflow   (overflow),
      .underflow  (underflow)
`endif
   );

   always #5 clk = ~clk;

   int unsigned     n_checks = 0;
   int unsigned     n_fail   = 0;
   logic [DW-1:0]   q[$];
   logic [DW-1:0]   exp_rdata = '0;
   bit              exp_ovf   = 1'b0;
   bit              exp_unf   = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      sync_fifo_count_t occ;
      occ = sync_fifo_count_t'(q.size());
      check_eq({tag, ".data_avail"}, 32'(data_avail), 32'(occ));
      check_eq({tag, ".room_avail"}, 32'(room_avail), 32'(DEPTH) - 32'(occ));
      check_eq({tag, ".is_empty"},   32'(is_empty),   32'(q.size() == 0));
      check_eq({tag, ".is_full"},    32'(is_full),    32'(q.size() == DEPTH));
      check_eq({tag, ".r_data"},     32'(r_data),     32'(exp_rdata));
`ifdef SYNC_FIFO_ERR_EN
      check_eq({tag, ".overflow"},   32'(overflow),   32'(exp_ovf));
      check_eq({tag, ".underflow"},  32'(underflow),  32'(exp_unf));
`endif
   endtask

   // Advance one clock with the current inputs and update the reference model.
   task automatic step(input string tag);
      bit wacc, racc;
      wacc    = w_en && (q.size() < DEPTH);
      racc    = r_en && (q.size() > 0);
      exp_ovf = w_en && (q.size() == DEPTH);
      exp_unf = r_en && (q.size() == 0);
      @(posedge clk);
      #1;
      if (racc) exp_rdata = q.pop_front();
      if (wacc) q.push_back(w_data);
      check_all(tag);
   endtask

   task automatic drive(input bit w, input bit r, input logic [DW-1:0] d, input string tag);
      w_en   = w;
      r_en   = r;
      w_data = d;
      step(tag);
   endtask

   task automatic model_reset();
      q.delete();
      exp_rdata = '0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; w_en = 1'b0; r_en = 1'b0; w_data = '0;
      #1;
      model_reset();
      check_all("reset0");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Random traffic, then reset asserted asynchronously mid-stream
      for (int i = 0; i < 30; i++)
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), DW'($urandom), "pre");
      w_en = 1'b1; r_en = 1'b1;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      check_eq("async_rst.room", 32'(room_avail), 32'd16);
      @(negedge clk);
      rst = 1'b0; w_en = 1'b0; r_en = 1'b0;

      for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, DW'(i), "fill");
      check_eq("fill.is_full", 32'(is_full), 32'd1);
      check_eq("fill.room", 32'(room_avail), 32'd0);
      drive(1'b1, 1'b0, 8'hAA, "fill_over");
      check_eq("fill_over.avail", 32'(data_avail), 32'd16);

      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b0, 1'b1, '0, "drain");
         check_eq("drain.seq", 32'(r_data), 32'(i));
      end
      check_eq("drain.is_empty", 32'(is_empty), 32'd1);
      drive(1'b0, 1'b1, '0, "drain_under");
      check_eq("drain_under.hold", 32'(r_data), 32'h0F);

      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, DW'(8'h50 + i), "sim_pre");
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, DW'($urandom), "sim");
         check_eq("sim.avail", 32'(data_avail), 32'd5);
      end
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, '0, "sim_drain");
      drive(1'b1, 1'b1, 8'h3C, "sim_empty");
      check_eq("sim_empty.avail", 32'(data_avail), 32'd1);
      drive(1'b0, 1'b1, '0, "sim_empty_rd");
      check_eq("sim_empty_rd.data", 32'(r_data), 32'h3C);

      // Full plus simultaneous request: only the read goes through
      for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, DW'($urandom), "refill");
      drive(1'b1, 1'b1, 8'hEE, "sim_full");
      check_eq("sim_full.avail", 32'(data_avail), 32'd15);
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, '0, "redrain");

      for (int i = 0; i < 40; i++)
         drive(1'(i % 2 == 0), 1'(i % 2 == 1), DW'($urandom), "wrap");

      for (int i = 0; i < 400; i++) begin
         int unsigned bias;
         bias = (i / 100) % 2 == 0 ? 3 : 1;
         drive(1'($urandom_range(0, 3) < bias), 1'($urandom_range(0, 3) >= bias),
               DW'($urandom), "rand");
      end

      w_en = 1'b0; r_en = 1'b0;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
